// File: rtl/spi_flash_read_ctrl.sv
// spi_flash_read_ctrl: single-word SPI mode-0 READ sequencer for the OBI SPI ROM frontend.
// Each accepted request produces one transfer (command, 24-bit aligned address,
// 32 data bits), followed by a one-cycle response pulse carrying the assembled word.
// Optional feature: define SPI_ROM_FAST_READ_EN to send opcode 8'h0B and insert
// eight dummy bits between the address and the data.
module spi_flash_read_ctrl #(
   parameter int         ClkDiv       = 2,
   parameter int         CsIdleCycles = 2,
   parameter logic [7:0] CmdRead      = 8'h03
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [23:0] req_addr_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data_o,
   output logic        busy_o,
   output logic        spi_cs_n_o,
   output logic        spi_sck_o,
   output logic        spi_mosi_o,
   input  logic        spi_miso_i
);

`ifdef SPI_ROM_FAST_READ_EN
   localparam logic [7:0] Opcode    = 8'h0B;
   localparam bit         HasDummy  = 1'b1;
   localparam logic [6:0] LastBit   = 7'd71;
`else
   localparam logic [7:0] Opcode    = CmdRead;
   localparam bit         HasDummy  = 1'b0;
   localparam logic [6:0] LastBit   = 7'd63;
`endif

   localparam int               DivW    = $clog2(ClkDiv) + 1;
   localparam logic [DivW-1:0]  DivLast = DivW'(ClkDiv - 1);
   localparam int               GapW    = $clog2(CsIdleCycles) + 1;
   localparam logic [GapW-1:0]  GapLast = GapW'(CsIdleCycles - 1);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StCmd   = 3'd1;
   localparam logic [2:0] StAddr  = 3'd2;
   localparam logic [2:0] StDummy = 3'd3;
   localparam logic [2:0] StData  = 3'd4;
   localparam logic [2:0] StGap   = 3'd5;

   logic [2:0]      state_reg;
   logic [6:0]      bit_cnt_reg;
   logic [DivW-1:0] div_cnt_reg;
   logic [GapW-1:0] gap_cnt_reg;
   logic [31:0]     tx_reg;
   logic [31:0]     rx_reg;
   logic [31:0]     rx_swapped;
   logic            sck_reg;
   logic            cs_n_reg;
   logic            mosi_reg;
   logic            rsp_valid_reg;
   logic [31:0]     rsp_data_reg;

   // Byte reorder: the first byte shifted in lands in the low byte of the response.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_swap
         assign rx_swapped[8*gi +: 8] = rx_reg[31-8*gi -: 8];
      end
   endgenerate

   // Transfer sequencer: accept, bit timing, shifting, response and CS gap.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= StIdle;
         bit_cnt_reg   <= '0;
         div_cnt_reg   <= '0;
         gap_cnt_reg   <= '0;
         tx_reg        <= '0;
         rx_reg        <= '0;
         sck_reg       <= 1'b0;
         cs_n_reg      <= 1'b1;
         mosi_reg      <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_data_reg  <= '0;
      end else begin
         rsp_valid_reg <= 1'b0;
         case (state_reg)
            StIdle: begin
               if (req_valid_i) begin
                  state_reg   <= StCmd;
                  cs_n_reg    <= 1'b0;
                  sck_reg     <= 1'b0;
                  mosi_reg    <= Opcode[7];
                  // Remaining bits after the one already on MOSI; zeros follow.
                  tx_reg      <= {Opcode[6:0], req_addr_i[23:2], 2'b00, 1'b0};
                  bit_cnt_reg <= '0;
                  div_cnt_reg <= '0;
               end
            end
            StCmd, StAddr, StDummy, StData: begin
               if (div_cnt_reg != DivLast) begin
                  div_cnt_reg <= div_cnt_reg + 1'b1;
               end else begin
                  div_cnt_reg <= '0;
                  if (!sck_reg) begin
                     sck_reg <= 1'b1;
                     if (state_reg == StData) begin
                        rx_reg <= {rx_reg[30:0], spi_miso_i};
                     end
                  end else if (bit_cnt_reg == LastBit) begin
                     sck_reg       <= 1'b0;
                     cs_n_reg      <= 1'b1;
                     mosi_reg      <= 1'b0;
                     rsp_valid_reg <= 1'b1;
                     rsp_data_reg  <= rx_swapped;
                     gap_cnt_reg   <= '0;
                     state_reg     <= StGap;
                  end else begin
                     sck_reg     <= 1'b0;
                     bit_cnt_reg <= bit_cnt_reg + 7'd1;
                     mosi_reg    <= tx_reg[31];
                     tx_reg      <= {tx_reg[30:0], 1'b0};
                     if (bit_cnt_reg == 7'd7) begin
                        state_reg <= StAddr;
                     end else if (bit_cnt_reg == 7'd31) begin
                        state_reg <= HasDummy ? StDummy : StData;
                     end else if (HasDummy && bit_cnt_reg == 7'd39) begin
                        state_reg <= StData;
                     end
                  end
               end
            end
            StGap: begin
               if (gap_cnt_reg == GapLast) begin
                  state_reg <= StIdle;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= StIdle;
         endcase
      end
   end

   assign req_ready_o = (state_reg == StIdle);
   assign busy_o      = (state_reg != StIdle);
   assign rsp_valid_o = rsp_valid_reg;
   assign rsp_data_o  = rsp_data_reg;
   assign spi_cs_n_o  = cs_n_reg;
   assign spi_sck_o   = sck_reg;
   assign spi_mosi_o  = mosi_reg;

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// Self-checking bench for spi_flash_read_ctrl: a time-based reference model of the
// pin activity is compared every cycle, plus literal checks per read.
// Build with SPI_ROM_FAST_READ_EN defined to exercise the fast-read variant (ClkDiv=1).
module tb_spi_flash_read_ctrl;

`ifdef SPI_ROM_FAST_READ_EN
   localparam int         CLK_DIV = 1;
   localparam int         NB      = 72;
   localparam int         DS      = 40;
   localparam int         LAT_LIT = 144;
   localparam logic [7:0] OP_LIT  = 8'h0B;
`else
   localparam int         CLK_DIV = 2;
   localparam int         NB      = 64;
   localparam int         DS      = 32;
   localparam int         LAT_LIT = 256;
   localparam logic [7:0] OP_LIT  = 8'h03;
`endif
   localparam int CS_IDLE = 2;
   localparam int T       = 2 * NB * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [23:0] req_addr_i = '0;
   logic        rsp_valid_o;
   logic [31:0] rsp_data_o;
   logic        busy_o;
   logic        spi_cs_n_o;
   logic        spi_sck_o;
   logic        spi_mosi_o;
   logic        spi_miso_i = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   spi_flash_read_ctrl #(
      .ClkDiv      (CLK_DIV),
      .CsIdleCycles(CS_IDLE),
      .CmdRead     (8'h03)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .req_addr_i (req_addr_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_data_o (rsp_data_o),
      .busy_o     (busy_o),
      .spi_cs_n_o (spi_cs_n_o),
      .spi_sck_o  (spi_sck_o),
      .spi_mosi_o (spi_mosi_o),
      .spi_miso_i (spi_miso_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- flash model ----------------
   logic [7:0]  tx_bytes [0:7][0:3];
   logic [7:0]  fl_bytes [0:3];
   int          fl_idx   = 0;
   int          rise_cnt = 0;
   logic [71:0] cap      = '0;

   // Capture MOSI on SCK rise; a CS fall starts a new transfer.
   always @(posedge spi_sck_o or negedge spi_cs_n_o) begin
      if (spi_sck_o === 1'b1) begin
         cap = {cap[70:0], spi_mosi_o};
         rise_cnt++;
      end else begin
         rise_cnt = 0;
         cap = '0;
         for (int i = 0; i < 4; i++) fl_bytes[i] = tx_bytes[fl_idx][i];
         fl_idx++;
      end
   end

   // Flash drives the next data bit on each SCK fall, bytes in order, MSB first.
   always @(negedge spi_sck_o) begin
      int d;
      if (rise_cnt >= DS && rise_cnt < NB) begin
         d = rise_cnt - DS;
         spi_miso_i = fl_bytes[d / 8][7 - (d % 8)];
      end else begin
         spi_miso_i = 1'b0;
      end
   end

   // ---------------- reference model + compare ----------------
   int          cyc = 0;
   bit          act = 1'b0;
   int          acc_c = 0;
   int          m_idx = 0;
   logic [23:0] m_addr = '0;
   logic [31:0] m_word = '0;
   logic [31:0] m_data = '0;
   int          hs_cnt = 0;
   int          rsp_cnt = 0;
   int          hs_cyc   [0:7];
   int          rsp_cyc  [0:7];
   int          rsp_rise [0:7];
   logic [31:0] rsp_val  [0:7];
   logic [71:0] rsp_cap  [0:7];
   int          cs_hi_run = 0;
   int          last_cs_hi_run = 0;

   function automatic logic stream_bit(input int b, input logic [23:0] a);
      logic [7:0] op;
      op = OP_LIT;
      if (b < 8)  return op[7 - b];
      if (b < 32) return a[23 - (b - 8)];
      return 1'b0;
   endfunction

   always @(negedge clk) begin
      logic e_cs, e_sck, e_mosi, e_rv, e_ready;
      int k;
      cyc++;
      if (rst_ni !== 1'b1) begin
         act    = 1'b0;
         m_data = '0;
         chk("rst_cs_n", spi_cs_n_o, 1);
         chk("rst_sck", spi_sck_o, 0);
         chk("rst_mosi", spi_mosi_o, 0);
         chk("rst_rsp_valid", rsp_valid_o, 0);
         chk("rst_rsp_data", rsp_data_o, 0);
         chk("rst_busy", busy_o, 0);
      end else begin
         e_cs = 1'b1; e_sck = 1'b0; e_mosi = 1'b0; e_rv = 1'b0; e_ready = 1'b1;
         if (act) begin
            k = cyc - acc_c - 1;
            e_ready = 1'b0;
            if (k < T) begin
               e_cs   = 1'b0;
               e_sck  = ((k / CLK_DIV) % 2) == 1;
               e_mosi = stream_bit(k / (2 * CLK_DIV), m_addr);
            end else if (k == T) begin
               e_rv   = 1'b1;
               m_data = m_word;
            end else if (k >= T + CS_IDLE) begin
               act     = 1'b0;
               e_ready = 1'b1;
            end
         end
         chk("cs_n", spi_cs_n_o, e_cs);
         chk("sck", spi_sck_o, e_sck);
         chk("mosi", spi_mosi_o, e_mosi);
         chk("rsp_valid", rsp_valid_o, e_rv);
         chk("rsp_data", rsp_data_o, m_data);
         chk("req_ready", req_ready_o, e_ready);
         chk("busy", busy_o, !e_ready);
         if (spi_cs_n_o === 1'b1) begin
            cs_hi_run++;
         end else if (cs_hi_run != 0) begin
            last_cs_hi_run = cs_hi_run;
            cs_hi_run = 0;
         end
         if (rsp_valid_o === 1'b1 && rsp_cnt < 8) begin
            rsp_cyc[rsp_cnt]  = cyc;
            rsp_val[rsp_cnt]  = rsp_data_o;
            rsp_cap[rsp_cnt]  = cap;
            rsp_rise[rsp_cnt] = rise_cnt;
            $display("[TB] read #%0d addr=%h data=%h cycle=%0d", rsp_cnt, m_addr, rsp_data_o, cyc);
            rsp_cnt++;
         end
         if (e_ready && req_valid_i && hs_cnt < 8) begin
            act    = 1'b1;
            acc_c  = cyc;
            m_addr = {req_addr_i[23:2], 2'b00};
            m_word = {tx_bytes[m_idx][3], tx_bytes[m_idx][2], tx_bytes[m_idx][1], tx_bytes[m_idx][0]};
            m_idx++;
            hs_cyc[hs_cnt] = cyc;
            hs_cnt++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_hs(input string nm, input int target, input int budget);
      for (int i = 0; i < budget && hs_cnt < target; i++) begin
         @(negedge clk); #1;
      end
      chk(nm, hs_cnt >= target, 1);
   endtask

   task automatic wait_rsp(input string nm, input int target, input int budget);
      for (int i = 0; i < budget && rsp_cnt < target; i++) begin
         @(negedge clk); #1;
      end
      chk(nm, rsp_cnt >= target, 1);
   endtask

   task automatic check_rsp(input int ri, input int hi, input logic [31:0] word,
                            input logic [23:0] addr, input string nm);
      if (ri >= rsp_cnt) return;
      chk({nm, "_data"}, rsp_val[ri], word);
      chk({nm, "_opcode"}, 32'(rsp_cap[ri][NB-1 -: 8]), 32'(OP_LIT));
      chk({nm, "_addr"}, 32'(rsp_cap[ri][NB-9 -: 24]), 32'(addr));
`ifdef SPI_ROM_FAST_READ_EN
      chk({nm, "_dummy"}, 32'(rsp_cap[ri][NB-33 -: 8]), 0);
`endif
      chk({nm, "_sck_edges"}, rsp_rise[ri], NB);
      chk({nm, "_latency"}, rsp_cyc[ri] - hs_cyc[hi] - 1, LAT_LIT);
   endtask

   task automatic do_read(input logic [23:0] addr, input logic [31:0] word,
                          input logic [23:0] exp_addr, input string nm);
      int h0, r0;
      h0 = hs_cnt;
      r0 = rsp_cnt;
      @(posedge clk); #1;
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      wait_hs({nm, "_accept_timeout"}, h0 + 1, 50);
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      wait_rsp({nm, "_rsp_timeout"}, r0 + 1, 3000);
      check_rsp(r0, h0, word, exp_addr, nm);
   endtask

   task automatic set_bytes(input int idx, input logic [31:0] word);
      for (int i = 0; i < 4; i++) tx_bytes[idx][i] = word[8*i +: 8];
   endtask

   initial begin
      int h0, r0;
      // Byte streams as the flash sends them: byte0 first.
      set_bytes(0, 32'hDEADBEEF);   // EF,BE,AD,DE
      set_bytes(1, 32'hDEADBEEF);
      set_bytes(2, 32'h12345678);   // 78,56,34,12
      set_bytes(3, 32'h44332211);   // 11,22,33,44
      set_bytes(4, 32'hAAAAAAAA);
      set_bytes(5, 32'h04030201);   // 01,02,03,04
      set_bytes(6, 32'h0);
      set_bytes(7, 32'h0);

      rst_ni = 1'b1;
      #1 rst_ni = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_cs_n", spi_cs_n_o, 1);
      chk("reset_sck", spi_sck_o, 0);
      chk("reset_rsp_data", rsp_data_o, 0);
      @(posedge clk); #1 rst_ni = 1'b1;
      @(negedge clk); #1;
      chk("reset_req_ready", req_ready_o, 1);
      chk("reset_busy", busy_o, 0);
      chk("reset_mosi", spi_mosi_o, 0);
      chk("reset_rsp_valid", rsp_valid_o, 0);

      do_read(24'h000104, 32'hDEADBEEF, 24'h000104, "read104");
      do_read(24'h000107, 32'hDEADBEEF, 24'h000104, "read107");

      // Held request: two back-to-back transfers.
      h0 = hs_cnt;
      r0 = rsp_cnt;
      @(posedge clk); #1;
      req_valid_i = 1'b1;
      req_addr_i  = 24'h000200;
      wait_hs("b2b_accept_timeout", h0 + 2, 3000);
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      wait_rsp("b2b_rsp_timeout", r0 + 2, 3000);
      check_rsp(r0, h0, 32'h12345678, 24'h000200, "b2b_first");
      check_rsp(r0 + 1, h0 + 1, 32'h44332211, 24'h000200, "b2b_second");
      if (rsp_cnt >= r0 + 2) begin
         chk("b2b_accept_gap", hs_cyc[h0 + 1] - rsp_cyc[r0], 2);
         chk("b2b_cs_high_cycles", last_cs_hi_run, CS_IDLE + 1);
      end

      // Reset during the address phase aborts the transfer.
      h0 = hs_cnt;
      r0 = rsp_cnt;
      @(posedge clk); #1;
      req_valid_i = 1'b1;
      req_addr_i  = 24'h000104;
      wait_hs("abort_accept_timeout", h0 + 1, 50);
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      for (int i = 0; i < 500 && rise_cnt < 10; i++) @(negedge clk);
      chk("abort_reach_bit10", rise_cnt, 10);
      @(posedge clk); #2;
      rst_ni = 1'b0;
      #1;
      chk("abort_cs_n_async", spi_cs_n_o, 1);
      chk("abort_sck_async", spi_sck_o, 0);
      repeat (3) @(posedge clk);
      #1 rst_ni = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("abort_no_rsp", rsp_cnt, r0);
      do_read(24'h000000, 32'h04030201, 24'h000000, "read000");
      chk("abort_rsp_count", rsp_cnt, r0 + 1);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spi_flash_read_ctrl.md
Name: spi_flash_read_ctrl

Overview:
- Sequences the serial flash behind the OBI SPI ROM frontend. Accepts one word-read request at a time and drives a mode-0 SPI READ transaction (command, 24-bit address, 32 data bits). Returns the assembled 32-bit word as a one-cycle response pulse.
- Sits between the OBI ROM request/response registers and the chip-level SPI pads.

Parameters:
ClkDiv, 2, SCK half-period in clk_i cycles (>=1); SCK period = 2*ClkDiv cycles
CsIdleCycles, 2, minimum cycles CS stays high after a transfer before the next accept (>=1)
CmdRead, 8'h03, read opcode sent MSB first

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_valid_i  in  1  read request valid
req_ready_o  out  1  controller can accept a request
req_addr_i  in  24  flash byte address; bits [1:0] ignored
rsp_valid_o  out  1  one-cycle pulse, rsp_data_o valid
rsp_data_o  out  32  read word, little-endian byte assembly
busy_o  out  1  transfer or gap in progress
spi_cs_n_o  out  1  chip select, active low
spi_sck_o  out  1  serial clock, idle low (mode 0)
spi_mosi_o  out  1  serial data to flash
spi_miso_i  in  1  serial data from flash

Behaviour:
- Reset (async, any state): state=IDLE, spi_cs_n_o=1, spi_sck_o=0, spi_mosi_o=0, rsp_valid_o=0, rsp_data_o=0, busy_o=0. req_ready_o=1 once reset is released. A reset mid-transfer aborts it: no response is produced and CS deasserts immediately.
- States: IDLE -> CMD (8 bits) -> ADDR (24 bits) -> DATA (32 bits) -> GAP -> IDLE.
- req_ready_o = (state==IDLE). busy_o = !req_ready_o.
- Accept occurs on a clock edge with req_valid_i && req_ready_o. On that edge the controller latches {req_addr_i[23:2],2'b00}, drives CS low and SCK low, and presents MOSI = CmdRead[7].
- Bit timing: each bit is ClkDiv cycles with SCK low, then ClkDiv cycles with SCK high.
  - MOSI updates only on the edge that drives SCK low.
  - MISO is registered on the edge that drives SCK high.
  - All shifting is MSB first.
- MOSI content by phase: CMD sends CmdRead; ADDR sends the 24-bit aligned address; DATA drives 0. MISO is ignored during CMD and ADDR.
- Data assembly: the first received byte goes to rsp_data_o[7:0], the second to [15:8], the third to [23:16], the fourth to [31:24]. Within each byte, the first bit received is bit 7 of that byte.
- End of transfer: on the edge that ends the 64th bit's high phase:
  - CS goes high and SCK goes low.
  - rsp_valid_o=1 for exactly one cycle, and rsp_data_o updates at the same time.
  - state enters GAP.
- Latency: rsp_valid_o is high in the cycle beginning 128*ClkDiv edges after the accept edge. For the default ClkDiv=2 that is 256 cycles.
- rsp_data_o holds its value until the next response. rsp_valid_o has no backpressure.
- GAP lasts CsIdleCycles cycles, counting the rsp_valid cycle as the first. req_ready_o rises in the following cycle. CS is therefore high for at least CsIdleCycles+1 cycles between transfers, including the next accept cycle.
- req_valid_i while busy is ignored and not queued; the requester must hold it.
- Counters: the bit counter is 7 bits (0..63, or 0..71 with the optional feature). The divider counter is $clog2(ClkDiv)+1 bits and wraps at ClkDiv-1.

Optional Feature:
- Macro SPI_ROM_FAST_READ_EN.
- Defined: the opcode is fixed at 8'h0B. A DUMMY state of 8 bits (MOSI=0, MISO ignored) is inserted between ADDR and DATA. Latency becomes 144*ClkDiv. The bit counter runs 0..71.
- Undefined: CmdRead is used with no dummy phase, as described above.

Test Plan:
- Reset with no requests -> cs_n=1, sck=0, mosi=0, req_ready=1, rsp_valid=0, rsp_data=0, busy=0.
- ClkDiv=2, read 24'h000104; flash model returns bytes EF,BE,AD,DE -> MOSI stream 0x03,0x00,0x01,0x04; 64 SCK rising edges each 4 cycles apart; rsp_valid pulses 256 cycles after accept with rsp_data=32'hDEADBEEF.
- Unaligned addr 24'h000107 -> transmitted address 0x000104; same data as the previous read.
- req_valid held high for two reads -> second accept exactly 2 cycles after the first rsp_valid cycle; CS high >=3 cycles between transfers; two rsp_valid pulses with correct data.
- Assert rst_ni low during ADDR phase (bit 10) -> cs_n=1 asynchronously, no rsp_valid; after release, a read of 24'h000000 completes normally.
- Build with ClkDiv=1 and SPI_ROM_FAST_READ_EN -> opcode 0x0B, 8 idle MOSI bits after the address, rsp_valid 144 cycles after accept.
